// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// hazard_pkg : forwarding-select encodings and stall-reason enum.   rev 1.0
// ============================================================================
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [2:0] {
    STALL_NONE     = 3'd0,
    STALL_LOAD_USE = 3'd1,
    STALL_RAW      = 3'd2,
    STALL_WAW      = 3'd3,
    STALL_STRUCT   = 3'd4
  } stall_reason_e;

endpackage
`default_nettype wire

// File: rtl/hazard_sb_if.sv
`default_nettype none
// ============================================================================
// hazard_sb_if : pipeline <-> hazard unit signal bundle.            rev 1.0
// ============================================================================
interface hazard_sb_if #(
  parameter int REGS  = 32,
  parameter int CNT_W = 16
);
  import hazard_pkg::*;

  localparam int RA_W = $clog2(REGS);

  logic            MEM_rd_reg_write;
  logic            WB_rd_reg_write;
  logic [RA_W-1:0] EXEC_rs1;
  logic [RA_W-1:0] EXEC_rs2;
  logic [RA_W-1:0] MEM_rd;
  logic [RA_W-1:0] WB_rd;
  logic            FETCH_valid;
  logic [RA_W-1:0] FETCH_rs1;
  logic [RA_W-1:0] FETCH_rs2;
  logic [RA_W-1:0] FETCH_rd;
  logic            FETCH_rd_write;
  logic            FETCH_mc;
  logic [RA_W-1:0] EXEC_rd;
  logic            EXEC_mem2reg;
  logic            BRA;
  logic            JMP;
  logic            MC_issue;
  logic            MC_done;
  logic [RA_W-1:0] MC_rd;

  logic [1:0]      FWD_rs1;
  logic [1:0]      FWD_rs2;
  logic            FWD_rs1_fetch;
  logic            FWD_rs2_fetch;
  logic            FETCH_stall;
  logic            EXEC_stall;
  logic            EXEC_flush;
  logic            MEM_flush;
  logic            MC_full;
  logic [CNT_W-1:0] STALL_CNT;
  stall_reason_e   STALL_REASON;

  modport master (
    output MEM_rd_reg_write, WB_rd_reg_write, EXEC_rs1, EXEC_rs2, MEM_rd, WB_rd,
           FETCH_valid, FETCH_rs1, FETCH_rs2, FETCH_rd, FETCH_rd_write, FETCH_mc,
           EXEC_rd, EXEC_mem2reg, BRA, JMP, MC_issue, MC_done, MC_rd,
    input  FWD_rs1, FWD_rs2, FWD_rs1_fetch, FWD_rs2_fetch, FETCH_stall, EXEC_stall,
           EXEC_flush, MEM_flush, MC_full, STALL_CNT, STALL_REASON
  );

  modport slave (
    input  MEM_rd_reg_write, WB_rd_reg_write, EXEC_rs1, EXEC_rs2, MEM_rd, WB_rd,
           FETCH_valid, FETCH_rs1, FETCH_rs2, FETCH_rd, FETCH_rd_write, FETCH_mc,
           EXEC_rd, EXEC_mem2reg, BRA, JMP, MC_issue, MC_done, MC_rd,
    output FWD_rs1, FWD_rs2, FWD_rs1_fetch, FWD_rs2_fetch, FETCH_stall, EXEC_stall,
           EXEC_flush, MEM_flush, MC_full, STALL_CNT, STALL_REASON
  );

endinterface
`default_nettype wire

// File: rtl/hazard_fwd.sv
`default_nettype none
// ============================================================================
// hazard_fwd : EXEC operand forwarding select for one source.      rev 1.0
// ============================================================================
module hazard_fwd
  import hazard_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] i_rs,
  input  logic            i_mem_wr,
  input  logic [RA_W-1:0] i_mem_rd,
  input  logic            i_wb_wr,
  input  logic [RA_W-1:0] i_wb_rd,
  output logic [1:0]      o_sel
);

  always_comb begin
    o_sel = FWD_RF;
    // x0 reads as zero, so a pending write to it must never be forwarded
    if (i_rs != '0) begin
      if (i_mem_wr && (i_mem_rd == i_rs))
        o_sel = FWD_MEM;
      else if (i_wb_wr && (i_wb_rd == i_rs))
        o_sel = FWD_WB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_sb.sv
`default_nettype none
// ============================================================================
// hazard_sb : scoreboarded forwarding / stall / flush control.     rev 1.0
// ============================================================================
module hazard_sb
  import hazard_pkg::*;
#(
  parameter int REGS     = 32,
  parameter int MC_DEPTH = 2,
  parameter int CNT_W    = 16
) (
  input  logic      clk,
  input  logic      rst,
  hazard_sb_if.slave hz
);

  localparam int RA_W = $clog2(REGS);
  localparam int OC_W = $clog2(MC_DEPTH + 1);
  localparam logic [OC_W-1:0] C_OC_MAX = OC_W'(MC_DEPTH);

  logic [REGS-1:0]  r_sb;
  logic [REGS-1:0]  w_sb_nxt;
  logic [OC_W-1:0]  r_oc;
  logic [CNT_W-1:0] r_cnt;

  logic w_rel_rs1, w_rel_rs2, w_rel_rd;
  logic w_load_use, w_raw, w_waw, w_struct;
  logic w_stall, w_redirect, w_fetch_stall;
  stall_reason_e w_reason;

  hazard_fwd #(.RA_W(RA_W)) u_fwd_rs1 (
    .i_rs     (hz.EXEC_rs1),
    .i_mem_wr (hz.MEM_rd_reg_write),
    .i_mem_rd (hz.MEM_rd),
    .i_wb_wr  (hz.WB_rd_reg_write),
    .i_wb_rd  (hz.WB_rd),
    .o_sel    (hz.FWD_rs1)
  );

  hazard_fwd #(.RA_W(RA_W)) u_fwd_rs2 (
    .i_rs     (hz.EXEC_rs2),
    .i_mem_wr (hz.MEM_rd_reg_write),
    .i_mem_rd (hz.MEM_rd),
    .i_wb_wr  (hz.WB_rd_reg_write),
    .i_wb_rd  (hz.WB_rd),
    .o_sel    (hz.FWD_rs2)
  );

  assign hz.FWD_rs1_fetch = hz.WB_rd_reg_write && (hz.WB_rd == hz.FETCH_rs1) && (hz.WB_rd != '0);
  assign hz.FWD_rs2_fetch = hz.WB_rd_reg_write && (hz.WB_rd == hz.FETCH_rs2) && (hz.WB_rd != '0);

  // A pending bit retiring this very cycle is bypassed from the MC writeback
  assign w_rel_rs1 = hz.MC_done && (hz.MC_rd == hz.FETCH_rs1);
  assign w_rel_rs2 = hz.MC_done && (hz.MC_rd == hz.FETCH_rs2);
  assign w_rel_rd  = hz.MC_done && (hz.MC_rd == hz.FETCH_rd);

  assign w_load_use = hz.FETCH_valid && hz.EXEC_mem2reg && (hz.EXEC_rd != '0) &&
                      ((hz.EXEC_rd == hz.FETCH_rs1) || (hz.EXEC_rd == hz.FETCH_rs2));
  assign w_raw      = hz.FETCH_valid &&
                      ((r_sb[hz.FETCH_rs1] && !w_rel_rs1) || (r_sb[hz.FETCH_rs2] && !w_rel_rs2));
  assign w_waw      = hz.FETCH_valid && hz.FETCH_rd_write && r_sb[hz.FETCH_rd] && !w_rel_rd;
  assign w_struct   = hz.FETCH_valid && hz.FETCH_mc && (r_oc == C_OC_MAX) && !hz.MC_done;

  assign w_stall       = w_load_use | w_raw | w_waw | w_struct;
  assign w_redirect    = hz.BRA | hz.JMP;
  assign w_fetch_stall = w_stall & ~w_redirect;

  assign hz.FETCH_stall = w_fetch_stall;
  assign hz.EXEC_flush  = w_redirect | w_stall;
  assign hz.MEM_flush   = w_redirect;
  assign hz.EXEC_stall  = 1'b0;
  assign hz.MC_full     = (r_oc == C_OC_MAX);
  assign hz.STALL_CNT   = r_cnt;

  always_comb begin
    w_reason = STALL_NONE;
    if (w_load_use)    w_reason = STALL_LOAD_USE;
    else if (w_raw)    w_reason = STALL_RAW;
    else if (w_waw)    w_reason = STALL_WAW;
    else if (w_struct) w_reason = STALL_STRUCT;
  end
  assign hz.STALL_REASON = w_reason;

  // Set is applied after clear so back-to-back reuse of a register stays pending
  always_comb begin
    w_sb_nxt = r_sb;
    if (hz.MC_done)  w_sb_nxt[hz.MC_rd]   = 1'b0;
    if (hz.MC_issue) w_sb_nxt[hz.EXEC_rd] = 1'b1;
    w_sb_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sb  <= '0;
      r_oc  <= '0;
      r_cnt <= '0;
    end else begin
      r_sb <= w_sb_nxt;
      if (hz.MC_issue && !hz.MC_done && (r_oc != C_OC_MAX))
        r_oc <= r_oc + OC_W'(1);
      else if (hz.MC_done && !hz.MC_issue && (r_oc != '0))
        r_oc <= r_oc - OC_W'(1);
      if (w_fetch_stall && (r_cnt != '1))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  a_issue_when_full: assert property (@(posedge clk) disable iff (rst)
    !(hz.MC_issue && !hz.MC_done && (r_oc == C_OC_MAX)))
    else $error("hazard_sb: MC_issue with outstanding counter at MC_DEPTH");

  a_done_when_empty: assert property (@(posedge clk) disable iff (rst)
    !(hz.MC_done && !hz.MC_issue && (r_oc == '0)))
    else $error("hazard_sb: MC_done with no outstanding op");

endmodule
`default_nettype wire

// File: tb/tb_hazard_sb.sv
`default_nettype none
// ============================================================================
// tb_hazard_sb : directed + randomized bench against a behavioural model.
// ============================================================================
module tb_hazard_sb;
  import hazard_pkg::*;

  localparam int REGS  = 32;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_sb_if #(.REGS(REGS), .CNT_W(CNT_W)) hz ();

  hazard_sb #(.REGS(REGS), .MC_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: pending registers, in-flight destinations, stall count
  bit m_pend [REGS];
  int m_oc;
  int m_cnt;
  int m_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    if (hz.MEM_rd_reg_write && hz.MEM_rd == rs) return 2'b01;
    if (hz.WB_rd_reg_write && hz.WB_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit released(input logic [4:0] r);
    return hz.MC_done && (hz.MC_rd == r);
  endfunction

  function automatic bit exp_stall();
    bit lu, raw, waw, st;
    if (!hz.FETCH_valid) return 1'b0;
    lu  = hz.EXEC_mem2reg && hz.EXEC_rd != 0 &&
          (hz.EXEC_rd == hz.FETCH_rs1 || hz.EXEC_rd == hz.FETCH_rs2);
    raw = (m_pend[hz.FETCH_rs1] && !released(hz.FETCH_rs1)) ||
          (m_pend[hz.FETCH_rs2] && !released(hz.FETCH_rs2));
    waw = hz.FETCH_rd_write && m_pend[hz.FETCH_rd] && !released(hz.FETCH_rd);
    st  = hz.FETCH_mc && (m_oc == DEPTH) && !hz.MC_done;
    return lu || raw || waw || st;
  endfunction

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_oc  = 0;
    m_cnt = 0;
    m_q.delete();
  endtask

  task automatic model_check();
    bit s, r;
    s = exp_stall();
    r = hz.BRA || hz.JMP;
    chk("fwd_rs1",       hz.FWD_rs1, exp_fwd(hz.EXEC_rs1));
    chk("fwd_rs2",       hz.FWD_rs2, exp_fwd(hz.EXEC_rs2));
    chk("fwd_rs1_fetch", hz.FWD_rs1_fetch,
        hz.WB_rd_reg_write && hz.WB_rd == hz.FETCH_rs1 && hz.WB_rd != 0);
    chk("fwd_rs2_fetch", hz.FWD_rs2_fetch,
        hz.WB_rd_reg_write && hz.WB_rd == hz.FETCH_rs2 && hz.WB_rd != 0);
    chk("fetch_stall",   hz.FETCH_stall, s && !r);
    chk("exec_flush",    hz.EXEC_flush, s || r);
    chk("mem_flush",     hz.MEM_flush, r);
    chk("exec_stall",    hz.EXEC_stall, 1'b0);
    chk("mc_full",       hz.MC_full, m_oc == DEPTH);
    chk("stall_cnt",     hz.STALL_CNT, m_cnt);
  endtask

  task automatic model_update();
    bit fs;
    int idx;
    if (rst) begin
      model_reset();
      return;
    end
    fs = exp_stall() && !(hz.BRA || hz.JMP);
    if (hz.MC_issue && !hz.MC_done && m_oc < DEPTH) m_oc++;
    else if (hz.MC_done && !hz.MC_issue && m_oc > 0) m_oc--;
    if (hz.MC_done) begin
      m_pend[hz.MC_rd] = 1'b0;
      idx = -1;
      foreach (m_q[i]) if (idx < 0 && m_q[i] == int'(hz.MC_rd)) idx = i;
      if (idx >= 0) m_q.delete(idx);
      else if (m_q.size() > 0) m_q.delete(0);
    end
    if (hz.MC_issue) begin
      if (hz.EXEC_rd != 0) m_pend[hz.EXEC_rd] = 1'b1;
      m_q.push_back(int'(hz.EXEC_rd));
    end
    if (fs && m_cnt < CMAX) m_cnt++;
  endtask

  // Inputs are driven at posedge+1; checks run at negedge, model commits at posedge
  task automatic cycle();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    hz.MEM_rd_reg_write = 0; hz.WB_rd_reg_write = 0;
    hz.EXEC_rs1 = 0; hz.EXEC_rs2 = 0; hz.MEM_rd = 0; hz.WB_rd = 0;
    hz.FETCH_valid = 0; hz.FETCH_rs1 = 0; hz.FETCH_rs2 = 0; hz.FETCH_rd = 0;
    hz.FETCH_rd_write = 0; hz.FETCH_mc = 0; hz.EXEC_rd = 0; hz.EXEC_mem2reg = 0;
    hz.BRA = 0; hz.JMP = 0; hz.MC_issue = 0; hz.MC_done = 0; hz.MC_rd = 0;
  endtask

  task automatic rand_inputs();
    bit can_issue;
    rst = ($urandom_range(0, 199) == 0);
    hz.MEM_rd_reg_write = 1'($urandom_range(0, 1));
    hz.WB_rd_reg_write  = 1'($urandom_range(0, 1));
    hz.EXEC_rs1  = 5'($urandom_range(0, 7));
    hz.EXEC_rs2  = 5'($urandom_range(0, 7));
    hz.MEM_rd    = 5'($urandom_range(0, 7));
    hz.WB_rd     = 5'($urandom_range(0, 7));
    hz.FETCH_valid    = ($urandom_range(0, 3) != 0);
    hz.FETCH_rs1      = 5'($urandom_range(0, 7));
    hz.FETCH_rs2      = 5'($urandom_range(0, 7));
    hz.FETCH_rd       = 5'($urandom_range(0, 7));
    hz.FETCH_rd_write = 1'($urandom_range(0, 1));
    hz.FETCH_mc       = ($urandom_range(0, 2) == 0);
    hz.EXEC_rd        = 5'($urandom_range(0, 7));
    hz.EXEC_mem2reg   = ($urandom_range(0, 3) == 0);
    hz.BRA            = ($urandom_range(0, 7) == 0);
    hz.JMP            = ($urandom_range(0, 7) == 0);
    hz.MC_done = (m_q.size() > 0) && ($urandom_range(0, 3) == 0);
    hz.MC_rd   = 5'd0;
    if (hz.MC_done) hz.MC_rd = 5'(m_q[$urandom_range(0, m_q.size() - 1)]);
    can_issue   = (m_q.size() < DEPTH) || hz.MC_done;
    hz.MC_issue = can_issue && ($urandom_range(0, 2) == 0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state with idle inputs
    #2;
    chk("rst_fetch_stall", hz.FETCH_stall, 0);
    chk("rst_exec_flush",  hz.EXEC_flush, 0);
    chk("rst_mem_flush",   hz.MEM_flush, 0);
    chk("rst_mc_full",     hz.MC_full, 0);
    chk("rst_stall_cnt",   hz.STALL_CNT, 0);
    cycle();

    // Forwarding priority, then x0 never forwarded
    hz.MEM_rd_reg_write = 1; hz.MEM_rd = 5; hz.WB_rd_reg_write = 1; hz.WB_rd = 5; hz.EXEC_rs1 = 5;
    #2; chk("fwd_mem_priority", hz.FWD_rs1, 2'b01);
    cycle();
    hz.MEM_rd = 0; hz.WB_rd = 0; hz.EXEC_rs1 = 0;
    #2; chk("fwd_x0", hz.FWD_rs1, 2'b00);
    cycle();

    // Load-use: one stall cycle
    idle(); hz.FETCH_valid = 1; hz.EXEC_mem2reg = 1; hz.EXEC_rd = 7; hz.FETCH_rs2 = 7;
    #2; chk("lu_stall", hz.FETCH_stall, 1); chk("lu_flush", hz.EXEC_flush, 1);
    cycle();
    hz.EXEC_mem2reg = 0; hz.EXEC_rd = 0;
    #2; chk("lu_one_cycle", hz.FETCH_stall, 0); chk("lu_cnt", hz.STALL_CNT, 1);
    cycle();

    // MC RAW on x9 until MC_done names it
    idle(); hz.MC_issue = 1; hz.EXEC_rd = 9;
    cycle();
    idle(); hz.FETCH_valid = 1; hz.FETCH_rs1 = 9;
    repeat (3) begin
      #2; chk("raw_stall", hz.FETCH_stall, 1);
      cycle();
    end
    hz.MC_done = 1; hz.MC_rd = 9;
    #2; chk("raw_release", hz.FETCH_stall, 0);
    cycle();
    hz.MC_done = 0;
    #2; chk("raw_cleared", hz.FETCH_stall, 0); chk("raw_cnt", hz.STALL_CNT, 4);
    cycle();

    // Structural: fill to MC_DEPTH, third MC op stalls, done releases it
    idle(); hz.MC_issue = 1; hz.EXEC_rd = 3;
    cycle();
    hz.EXEC_rd = 4;
    cycle();
    idle(); hz.FETCH_valid = 1; hz.FETCH_mc = 1;
    #2; chk("mc_full_two", hz.MC_full, 1); chk("struct_stall", hz.FETCH_stall, 1);
    cycle();
    hz.MC_done = 1; hz.MC_rd = 3;
    #2; chk("struct_release", hz.FETCH_stall, 0);
    cycle();

    // Redirect overrides a RAW stall and leaves the scoreboard intact
    idle(); hz.FETCH_valid = 1; hz.FETCH_rs1 = 4; hz.BRA = 1;
    #2; chk("redir_no_stall", hz.FETCH_stall, 0); chk("redir_exec_flush", hz.EXEC_flush, 1);
    chk("redir_mem_flush", hz.MEM_flush, 1);
    cycle();
    hz.BRA = 0;
    #2; chk("redir_sb_kept", hz.FETCH_stall, 1);
    cycle();

    // Reset mid-flight with two ops outstanding
    idle(); hz.MC_issue = 1; hz.EXEC_rd = 3;
    cycle();
    idle();
    #2; chk("midflight_full", hz.MC_full, 1);
    rst = 1;
    cycle();
    rst = 0; hz.FETCH_valid = 1; hz.FETCH_rs1 = 3; hz.FETCH_rd_write = 1; hz.FETCH_rd = 4;
    #2; chk("post_rst_stall", hz.FETCH_stall, 0); chk("post_rst_full", hz.MC_full, 0);
    chk("post_rst_cnt", hz.STALL_CNT, 0);
    cycle();

    // Stall counter saturation
    idle(); hz.MC_issue = 1; hz.EXEC_rd = 5;
    cycle();
    idle(); hz.FETCH_valid = 1; hz.FETCH_rs1 = 5;
    repeat (CMAX + 5) cycle();
    chk("cnt_saturate", hz.STALL_CNT, CMAX);
    idle(); hz.MC_done = 1; hz.MC_rd = 5;
    cycle();
    idle();

    repeat (1500) begin
      rand_inputs();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
